// File: rtl/dqs_burst_gen.sv
// DDR3 write DQS strobe pattern generator.
// Produces the per-clock 2-bit pattern and output enable for the ODDR/OBUFDS stage:
// preamble, toggling strobe for len+1 cycles, postamble, then release.
// Back-to-back bursts chain seamlessly when start arrives on the last toggle cycle.
//
// Ports:
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   start  in   burst request, taken only while ready=1
//   len    in   burst length minus 1, captured with an accepted start
//   ready  out  start will be accepted this cycle (combinational)
//   busy   out  not idle
//   oe     out  strobe output enable (registered)
//   din    out  DDR pattern, din[0] first half, din[1] second half (registered)
//   done   out  one-cycle pulse on the cycle oe has just fallen
module dqs_burst_gen #(
  parameter int unsigned LEN_WIDTH   = 6,
  parameter int unsigned PRE_CYCLES  = 1,
  parameter int unsigned POST_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [LEN_WIDTH-1:0] len,
  output logic                 ready,
  output logic                 busy,
  output logic                 oe,
  output logic [1:0]           din,
  output logic                 done
);

  localparam int unsigned PreW  = (PRE_CYCLES > 1) ? $clog2(PRE_CYCLES) : 1;
  localparam int unsigned PostW = (POST_CYCLES > 1) ? $clog2(POST_CYCLES) : 1;
  localparam int unsigned PpW   = (PreW > PostW) ? PreW : PostW;
  localparam int unsigned CntW  = (LEN_WIDTH > PpW) ? LEN_WIDTH : PpW;

  localparam logic [CntW-1:0] PreLoad  = CntW'(PRE_CYCLES - 1);
  localparam logic [CntW-1:0] PostLoad = CntW'(POST_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StPre, StToggle, StPost} state_e;

  state_e               state_q;
  logic [CntW-1:0]      cnt_q;
  logic [LEN_WIDTH-1:0] len_q;
  logic                 oe_q;
  logic [1:0]           din_q;
  logic                 done_q;
  logic                 cnt_zero;

  assign cnt_zero = (cnt_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      len_q   <= '0;
      oe_q    <= 1'b0;
      din_q   <= 2'b00;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StPre;
            cnt_q   <= PreLoad;
            len_q   <= len;
            oe_q    <= 1'b1;
            din_q   <= 2'b00;
          end
        end
        StPre: begin
          if (cnt_zero) begin
            state_q <= StToggle;
            cnt_q   <= CntW'(len_q);
            din_q   <= 2'b01;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StToggle: begin
          if (cnt_zero) begin
            if (start) begin
              // Seamless chaining: keep toggling, reload with the new length.
              cnt_q <= CntW'(len);
              len_q <= len;
            end else begin
              state_q <= StPost;
              cnt_q   <= PostLoad;
              din_q   <= 2'b00;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StPost: begin
          if (cnt_zero) begin
            state_q <= StIdle;
            oe_q    <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          cnt_q   <= '0;
          oe_q    <= 1'b0;
          din_q   <= 2'b00;
        end
      endcase
    end
  end

  assign ready = (state_q == StIdle) | ((state_q == StToggle) & cnt_zero);
  assign busy  = (state_q != StIdle);
  assign oe    = oe_q;
  assign din   = din_q;
  assign done  = done_q;

endmodule
